uart_reg_responder: RTL

Byte-level command responder on the FIFO side of the UART block. Pops command frames from the UART RX FIFO, executes register-bank reads and writes, and pushes one response byte per frame into the UART TX FIFO. It is the device end of the host-initiated serial register-access link. It connects directly to the UART's ReadUart, ReadData, RxEmpty, WriteUart, WriteData and TxFull ports.

---
 rtl/uart_reg_responder_pkg.sv | 24 ++
 rtl/uart_reg_responder_bank.sv | 40 ++++
 rtl/uart_reg_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_reg_responder_pkg.sv
// Shared types and constants for the UART register responder.
// Holds the FSM state encoding, the command/response byte codes
// and a saturating increment helper for the 8-bit error counter.
package uart_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_EXEC,
        ST_SEND
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    // Counter sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_reg_responder_bank.sv
// Register bank for the UART responder: NUM_REGS x DATA_BITS storage.
// Ports: Clock/Reset (sync clear), WrEn/WrAddr/WrData synchronous write,
//        RdAddr/RdData asynchronous read, Regs flattened view of all registers.
module uart_reg_bank #(
    parameter int DATA_BITS = 8,
    parameter int NUM_REGS  = 16,
    parameter int AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          WrEn,
    input  logic [AW-1:0]                 WrAddr,
    input  logic [DATA_BITS-1:0]          WrData,
    input  logic [AW-1:0]                 RdAddr,
    output logic [DATA_BITS-1:0]          RdData,
    output logic [NUM_REGS*DATA_BITS-1:0] Regs
);

    logic [DATA_BITS-1:0] r_regs [NUM_REGS];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (WrEn) begin
            r_regs[WrAddr] <= WrData;
        end
    end

    assign RdData = r_regs[RdAddr];

    always_comb begin
        Regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            Regs[i*DATA_BITS +: DATA_BITS] = r_regs[i];
        end
    end

endmodule

// File: rtl/uart_reg_responder.sv
// Command responder between UART RX/TX FIFOs and a register bank: pops
// write (0x57,addr,data) / read (0x52,addr) frames, pushes one response byte.
// Ports: Clock, Reset (sync, active-high); RxEmpty/ReadData/ReadUart on the RX
// FIFO; TxFull/WriteData/WriteUart on the TX FIFO; Regs, Busy, ErrorCount status.
// Optional in-frame idle timeout enabled by defining UART_RESPONDER_TIMEOUT_EN.
module uart_reg_responder
    import uart_responder_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int NUM_REGS       = 16,
    parameter int TIMEOUT_CYCLES = 130208
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          RxEmpty,
    input  logic [DATA_BITS-1:0]          ReadData,
    output logic                          ReadUart,
    input  logic                          TxFull,
    output logic [DATA_BITS-1:0]          WriteData,
    output logic                          WriteUart,
    output logic [NUM_REGS*DATA_BITS-1:0] Regs,
    output logic                          Busy,
    output logic [7:0]                    ErrorCount
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [DATA_BITS:0] ADDR_LIMIT = (DATA_BITS+1)'(NUM_REGS);

    state_t               r_state;
    logic                 r_is_write;
    logic [DATA_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_data;
    logic [DATA_BITS-1:0] r_rsp;
    logic [7:0]           r_err;

    logic                 w_addr_ok;
    logic                 w_wr_en;
    logic                 w_in_rx_state;
    logic                 w_timeout;
    logic [DATA_BITS-1:0] w_rd_data;

    assign w_addr_ok     = ({1'b0, r_addr} < ADDR_LIMIT);
    assign w_wr_en       = (r_state == ST_EXEC) && r_is_write && w_addr_ok;
    assign w_in_rx_state = (r_state == ST_IDLE) || (r_state == ST_GET_ADDR) ||
                           (r_state == ST_GET_DATA);

`ifdef UART_RESPONDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] r_timer;
    logic          w_starving;

    // Only counts while a frame is open and the FIFO has nothing for us.
    assign w_starving = ((r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA)) && RxEmpty;
    assign w_timeout  = w_starving && (r_timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clock) begin
        if (Reset || !w_starving || w_timeout) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
`endif

    uart_reg_bank #(
        .DATA_BITS(DATA_BITS),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_bank (
        .Clock (Clock),
        .Reset (Reset),
        .WrEn  (w_wr_en),
        .WrAddr(r_addr[AW-1:0]),
        .WrData(r_data),
        .RdAddr(r_addr[AW-1:0]),
        .RdData(w_rd_data),
        .Regs  (Regs)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rsp      <= '0;
            r_err      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!RxEmpty) begin
                        if (ReadData == DATA_BITS'(CMD_WRITE)) begin
                            r_is_write <= 1'b1;
                            r_state    <= ST_GET_ADDR;
                        end else if (ReadData == DATA_BITS'(CMD_READ)) begin
                            r_is_write <= 1'b0;
                            r_state    <= ST_GET_ADDR;
                        end else begin
                            // Unknown opcode: single-byte frame, NAK straight away.
                            r_rsp   <= DATA_BITS'(RSP_NAK);
                            r_err   <= sat_inc(r_err);
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (!RxEmpty) begin
                        r_addr  <= ReadData;
                        r_state <= r_is_write ? ST_GET_DATA : ST_EXEC;
                    end else if (w_timeout) begin
                        r_err   <= sat_inc(r_err);
                        r_state <= ST_IDLE;
                    end
                end
                ST_GET_DATA: begin
                    // Data byte is taken even for a bad address so framing stays fixed.
                    if (!RxEmpty) begin
                        r_data  <= ReadData;
                        r_state <= ST_EXEC;
                    end else if (w_timeout) begin
                        r_err   <= sat_inc(r_err);
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (!w_addr_ok) begin
                        r_rsp <= DATA_BITS'(RSP_NAK);
                        r_err <= sat_inc(r_err);
                    end else if (r_is_write) begin
                        r_rsp <= DATA_BITS'(RSP_ACK);
                    end else begin
                        r_rsp <= w_rd_data;
                    end
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (!TxFull) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // FIFO strobes follow the FIFO flags combinationally so a byte can move every cycle.
    assign ReadUart   = !Reset && w_in_rx_state && !RxEmpty;
    assign WriteUart  = !Reset && (r_state == ST_SEND) && !TxFull;
    assign WriteData  = r_rsp;
    assign Busy       = !Reset && (r_state != ST_IDLE);
    assign ErrorCount = r_err;

endmodule
